fp_max_tracker: RTL and testbench
=================================

FP_MAX_TRACKER -- requirements
Module: fp_max_tracker

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of operands per frame (N >= 1).
REQ-002 SHALL have parameter IDX_W, default 3, meaning index width (2**IDX_W >= N).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, frame start request (level-sampled).
REQ-006 SHALL have port din_valid, input, 1, operand valid.
REQ-007 SHALL have port din_sign, input, 1, operand sign (1 = negative).
REQ-008 SHALL have port din_exp, input, 4, operand exponent.
REQ-009 SHALL have port din_frac, input, 8, operand fraction (normalized, MSB set for nonzero).
REQ-010 SHALL have port din_ready, output, 1, operand accepted on clk edge when din_valid && din_ready.
REQ-011 SHALL have port busy, output, 1, frame in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when result is valid.
REQ-013 SHALL have port max_sign / max_exp / max_frac, output, 1/4/8, running or final maximum.
REQ-014 SHALL have port max_idx, output, IDX_W, 0-based index in frame of the maximum.

Function
REQ-015 SHALL implement FSM states IDLE, FIRST, CMP, DONE.
REQ-016 In IDLE: din_ready=0, busy=0; start=1 -> FIRST next cycle; operand count cleared.
REQ-017 In FIRST: din_ready=1, busy=1; on handshake load operand into max registers, max_idx=0, count=1; go to DONE if N==1, else CMP.
REQ-018 In CMP: din_ready=1, busy=1; on handshake replace max registers and max_idx with operand/count only if operand > current max; increment count; after the Nth accepted operand go to DONE.
REQ-019 Without a handshake, FIRST/CMP SHALL hold state, count and max registers unchanged (arbitrary stall length).
REQ-020 In DONE: done=1 for exactly one cycle, busy=0, din_ready=0; max outputs hold final result; next state IDLE.
REQ-021 Max outputs SHALL hold their value in IDLE until the next FIRST-state load.
REQ-022 Ordering: positive > negative; same sign positive: larger {exp,frac} is greater; same sign negative: smaller {exp,frac} is greater; equal values not greater.
REQ-023 Ties SHALL keep the earliest index (strict greater-than replaces).
REQ-024 start while busy or in DONE SHALL be ignored; start held high in IDLE after DONE begins a new frame.
REQ-025 din_valid in IDLE/DONE SHALL be ignored and no operand consumed.
REQ-026 Comparison SHALL be combinational against the registered max: one operand per cycle throughput, done asserted the cycle after the Nth handshake.
REQ-027 Count SHALL be IDX_W+1 bits wide so count==N is representable with no wrap.

Reset
REQ-028 reset_n=0 SHALL asynchronously force IDLE, count=0, max_sign=0, max_exp=0, max_frac=0, max_idx=0, done=0, busy=0, din_ready=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no done pulse; first frame after release requires a fresh start.

Structure
REQ-030 FSM state encoding and the 13-bit operand field widths (1/4/8) SHALL be constants in a shared fp package.
REQ-031 The greater-than decision SHALL be one instance of the existing fp_gt sub-module (sign/exp/frac pairs in, gt out); no duplicate compare logic.

Verification
REQ-032 N=4, operands +1.0(e=0,f=0x80), +3.0(e=1,f=0xC0), +2.0(e=1,f=0x80), -5.0 back-to-back -> done 1 cycle after 4th handshake, max=+3.0 (0,1,0xC0), max_idx=1.
REQ-033 N=4, all negative -4,-1,-2,-1 -> max=-1.0 (1,0,0x80), max_idx=1 (tie keeps earliest).
REQ-034 N=4, din_valid gapped with 3 idle cycles between operands, start pulsed again mid-frame -> same result as gap-free run, start ignored, single done pulse.
REQ-035 Assert reset_n=0 after 2 of 4 operands -> outputs zero immediately, no done; new frame after start returns correct max.
REQ-036 N=1, single operand -7.5 -> done 1 cycle after handshake, max=-7.5, max_idx=0.
REQ-037 din_valid=1 in IDLE with start=0 for 10 cycles -> din_ready=0, no state change, outputs unchanged.

Source files
------------

// File: rtl/fp_max_tracker_pkg.sv
// Shared constants for the floating-point max tracker: operand field widths
// and the frame-control FSM state encoding.
package fp_max_tracker_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_CMP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_max_tracker_gt.sv
// fp_gt: strict greater-than between two sign/exp/frac operands (a > b).
// Sign-magnitude ordering: positive beats negative, so +0 > -0.
module fp_gt
  import fp_max_tracker_pkg::*;
(
  input  logic              a_sign,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [FRAC_W-1:0] a_frac,
  input  logic              b_sign,
  input  logic [EXP_W-1:0]  b_exp,
  input  logic [FRAC_W-1:0] b_frac,
  output logic              gt
);

  // Mixed signs decide on sign alone; negatives order by reversed magnitude.
  always_comb begin
    gt = 1'b0;
    if (a_sign != b_sign) begin
      gt = b_sign;
    end else if (a_sign == 1'b0) begin
      gt = ({a_exp, a_frac} > {b_exp, b_frac});
    end else begin
      gt = ({a_exp, a_frac} < {b_exp, b_frac});
    end
  end

endmodule

// File: rtl/fp_max_tracker.sv
// Tracks the maximum of N floating-point operands per frame, with its index,
// accepting one operand per cycle and pulsing done when the frame completes.
module fp_max_tracker
  import fp_max_tracker_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              din_valid,
  input  logic              din_sign,
  input  logic [EXP_W-1:0]  din_exp,
  input  logic [FRAC_W-1:0] din_frac,
  output logic              din_ready,
  output logic              busy,
  output logic              done,
  output logic              max_sign,
  output logic [EXP_W-1:0]  max_exp,
  output logic [FRAC_W-1:0] max_frac,
  output logic [IDX_W-1:0]  max_idx
);

  // One extra bit so count can reach N without wrapping.
  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(N - 1);
  localparam logic [IDX_W:0] ONE_CNT  = (IDX_W+1)'(1);

  state_e              state_q, state_d;
  logic [IDX_W:0]      count_q, count_d;
  logic                max_sign_q, max_sign_d;
  logic [EXP_W-1:0]    max_exp_q, max_exp_d;
  logic [FRAC_W-1:0]   max_frac_q, max_frac_d;
  logic [IDX_W-1:0]    max_idx_q, max_idx_d;
  logic                gt_s;

  fp_gt u_gt (
    .a_sign (din_sign),
    .a_exp  (din_exp),
    .a_frac (din_frac),
    .b_sign (max_sign_q),
    .b_exp  (max_exp_q),
    .b_frac (max_frac_q),
    .gt     (gt_s)
  );

  // Next-state, running-max update and state-decoded handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    max_sign_d = max_sign_q;
    max_exp_d  = max_exp_q;
    max_frac_d = max_frac_q;
    max_idx_d  = max_idx_q;
    din_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (start) begin
          state_d = ST_FIRST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FIRST: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (din_valid) begin
          max_sign_d = din_sign;
          max_exp_d  = din_exp;
          max_frac_d = din_frac;
          max_idx_d  = '0;
          count_d    = ONE_CNT;
          state_d    = (N == 1) ? ST_DONE : ST_CMP;
        end else begin
          state_d = ST_FIRST;
        end
      end
      ST_CMP: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (din_valid) begin
          // Strict greater-than: ties keep the earlier index.
          if (gt_s) begin
            max_sign_d = din_sign;
            max_exp_d  = din_exp;
            max_frac_d = din_frac;
            max_idx_d  = count_q[IDX_W-1:0];
          end else begin
            max_idx_d = max_idx_q;
          end
          count_d = count_q + ONE_CNT;
          if (count_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CMP;
          end
        end else begin
          state_d = ST_CMP;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand count and running-max registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      max_sign_q <= 1'b0;
      max_exp_q  <= '0;
      max_frac_q <= '0;
      max_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      max_sign_q <= max_sign_d;
      max_exp_q  <= max_exp_d;
      max_frac_q <= max_frac_d;
      max_idx_q  <= max_idx_d;
    end
  end

  assign max_sign = max_sign_q;
  assign max_exp  = max_exp_q;
  assign max_frac = max_frac_q;
  assign max_idx  = max_idx_q;

endmodule

// File: tb/tb_fp_max_tracker.sv
// Self-checking bench for fp_max_tracker: directed frames plus randomized
// frames checked against a real-number reference model.
module tb_fp_max_tracker;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // N=4 instance
  logic       start4, v4, sg4, r4, b4, d4, ms4;
  logic [3:0] e4, me4;
  logic [7:0] f4, mf4;
  logic [2:0] mi4;
  // N=1 instance
  logic       start1, v1, sg1, r1, b1, d1, ms1;
  logic [3:0] e1, me1;
  logic [7:0] f1, mf1;
  logic [2:0] mi1;

  fp_max_tracker #(.N(4), .IDX_W(3)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .din_valid(v4),
    .din_sign(sg4), .din_exp(e4), .din_frac(f4), .din_ready(r4),
    .busy(b4), .done(d4), .max_sign(ms4), .max_exp(me4),
    .max_frac(mf4), .max_idx(mi4)
  );

  fp_max_tracker #(.N(1), .IDX_W(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .din_valid(v1),
    .din_sign(sg1), .din_exp(e1), .din_frac(f1), .din_ready(r1),
    .busy(b1), .done(d1), .max_sign(ms1), .max_exp(me1),
    .max_frac(mf1), .max_idx(mi1)
  );

  int total = 0;
  int bad   = 0;
  int dcnt4 = 0;
  int dcnt1 = 0;
  logic [12:0] ops [4];
  logic [12:0] last_max;
  int          last_idx;

  always @(negedge clk) begin
    if (d4) dcnt4 <= dcnt4 + 1;
    if (d1) dcnt1 <= dcnt1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Operand as a real number: frac/128 * 2^exp, negated when sign set.
  function automatic real fp_val(input logic [12:0] v);
    real m;
    m = (real'(v[7:0]) / 128.0) * (2.0 ** real'(v[11:8]));
    return v[12] ? -m : m;
  endfunction

  function automatic int model_max_idx();
    int mi;
    mi = 0;
    for (int i = 1; i < 4; i++)
      if (fp_val(ops[i]) > fp_val(ops[mi])) mi = i;
    return mi;
  endfunction

  function automatic logic [12:0] rand_op();
    logic [12:0] v;
    v = {1'($urandom), 4'($urandom), 1'b1, 7'($urandom)};
    return v;
  endfunction

  // Full N=4 frame: optional idle gaps between operands, optional start pokes.
  task automatic run4(input int gap, input bit poke);
    int mi;
    int dbefore;
    mi = model_max_idx();
    dbefore = dcnt4;
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    chk("busy_first", 32'(b4), 1);
    for (int i = 0; i < 4; i++) begin
      v4 = 1'b1;
      {sg4, e4, f4} = ops[i];
      chk("ready_busy", 32'(r4), 1);
      @(posedge clk); #1 v4 = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          {sg4, e4, f4} = rand_op();
          start4 = poke;
          @(posedge clk); #1 start4 = 1'b0;
          chk("stall_busy", 32'(b4), 1);
        end
      end
    end
    chk("done_pulse", 32'(d4), 1);
    chk("done_busy", 32'(b4), 0);
    chk("done_ready", 32'(r4), 0);
    chk("max_sign", 32'(ms4), 32'(ops[mi][12]));
    chk("max_exp", 32'(me4), 32'(ops[mi][11:8]));
    chk("max_frac", 32'(mf4), 32'(ops[mi][7:0]));
    chk("max_idx", 32'(mi4), 32'(mi));
    @(posedge clk); #1;
    chk("done_clear", 32'(d4), 0);
    chk("done_count", 32'(dcnt4), 32'(dbefore + 1));
    last_max = ops[mi];
    last_idx = mi;
  endtask

  initial begin
    int dsave;
    int pick;
    logic [12:0] pool [4];
    reset_n = 1'b0;
    start4 = 1'b0; v4 = 1'b0; {sg4, e4, f4} = '0;
    start1 = 1'b0; v1 = 1'b0; {sg1, e1, f1} = '0;
    #3;
    chk("rst_busy", 32'(b4), 0);
    chk("rst_ready", 32'(r4), 0);
    chk("rst_done", 32'(d4), 0);
    chk("rst_max", 32'({ms4, me4, mf4, mi4}), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // +1, +3, +2, -5 back-to-back
    ops[0] = {1'b0, 4'd0, 8'h80}; ops[1] = {1'b0, 4'd1, 8'hC0};
    ops[2] = {1'b0, 4'd1, 8'h80}; ops[3] = {1'b1, 4'd2, 8'hA0};
    run4(0, 1'b0);
    chk("dir_pos_idx", 32'(mi4), 1);
    chk("dir_pos_val", 32'({ms4, me4, mf4}), 32'({1'b0, 4'd1, 8'hC0}));

    // -4, -1, -2, -1: tie keeps index 1
    ops[0] = {1'b1, 4'd2, 8'h80}; ops[1] = {1'b1, 4'd0, 8'h80};
    ops[2] = {1'b1, 4'd1, 8'h80}; ops[3] = {1'b1, 4'd0, 8'h80};
    run4(0, 1'b0);
    chk("dir_neg_idx", 32'(mi4), 1);

    // Same first frame, gapped, with start poked mid-frame
    ops[0] = {1'b0, 4'd0, 8'h80}; ops[1] = {1'b0, 4'd1, 8'hC0};
    ops[2] = {1'b0, 4'd1, 8'h80}; ops[3] = {1'b1, 4'd2, 8'hA0};
    run4(3, 1'b1);
    chk("gap_idx", 32'(mi4), 1);

    // Idle with din_valid held: nothing consumed, outputs hold
    dsave = dcnt4;
    for (int c = 0; c < 10; c++) begin
      v4 = 1'b1; start4 = 1'b0; {sg4, e4, f4} = rand_op();
      @(posedge clk); #1;
      chk("idle_ready", 32'(r4), 0);
      chk("idle_busy", 32'(b4), 0);
      chk("idle_hold", 32'({ms4, me4, mf4}), 32'(last_max));
    end
    v4 = 1'b0;
    chk("idle_idx_hold", 32'(mi4), 32'(last_idx));
    chk("idle_no_done", 32'(dcnt4), 32'(dsave));

    // Reset after 2 of 4 operands
    dsave = dcnt4;
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v4 = 1'b1; {sg4, e4, f4} = {1'b0, 4'd5, 8'hFF};
      @(posedge clk); #1 v4 = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_max", 32'({ms4, me4, mf4, mi4}), 0);
    chk("midrst_busy", 32'(b4), 0);
    chk("midrst_ready", 32'(r4), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    v4 = 1'b1;
    repeat (3) @(posedge clk);
    #1 v4 = 1'b0;
    chk("postrst_idle", 32'(b4), 0);
    chk("postrst_no_done", 32'(dcnt4), 32'(dsave));
    chk("postrst_max", 32'({ms4, me4, mf4}), 0);
    run4(0, 1'b0);

    // N=1 instance: single -7.5
    dsave = dcnt1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    v1 = 1'b1; {sg1, e1, f1} = {1'b1, 4'd2, 8'hF0};
    chk("n1_ready", 32'(r1), 1);
    @(posedge clk); #1 v1 = 1'b0;
    chk("n1_done", 32'(d1), 1);
    chk("n1_max", 32'({ms1, me1, mf1}), 32'({1'b1, 4'd2, 8'hF0}));
    chk("n1_idx", 32'(mi1), 0);
    @(posedge clk); #1;
    chk("n1_done_clear", 32'(d1), 0);
    chk("n1_done_count", 32'(dcnt1), 32'(dsave + 1));

    // Randomized frames, drawing from a small pool to force ties
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < 4; k++) pool[k] = rand_op();
      for (int k = 0; k < 4; k++) begin
        pick = int'($urandom_range(0, 4));
        ops[k] = (pick < 4) ? pool[pick] : rand_op();
      end
      run4(int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
